// File: rtl/cnt_pkg.sv
// ============================================================================
// Module      : cnt_pkg
// Description : Opcodes shared by the cycle counters and the transfer FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt_pkg;

    typedef enum logic [1:0] {
        OPC_HOLD  = 2'b00,
        OPC_COUNT = 2'b01,
        OPC_CLEAR = 2'b10,
        OPC_LOAD  = 2'b11
    } opc_e;

    // Start value of a word: 0 when counting up, the terminal count when down.
    function automatic logic [31:0] start_value(input logic down, input logic [31:0] tc);
        return down ? tc : 32'd0;
    endfunction

endpackage : cnt_pkg

`default_nettype wire

// File: rtl/frm_counter.sv
// ============================================================================
// Module      : frm_counter
// Description : Counts completed words and pulses at the end of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frm_counter #(
    parameter int Frames   = 4,
    parameter int FrmWidth = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc,
    input  logic                clr,
    output logic [FrmWidth-1:0] frm_cnt_o,
    output logic                frm_done
);

    localparam logic [FrmWidth-1:0] LAST_FRM = FrmWidth'(Frames - 1);

    logic [FrmWidth-1:0] frm_q;
    logic [FrmWidth-1:0] frm_d;
    logic                frm_done_q;
    logic                frm_done_d;

    always_comb begin
        frm_d      = frm_q;
        frm_done_d = 1'b0;
        if (clr) begin
            frm_d = '0;
        end else if (inc) begin
            if (frm_q == LAST_FRM) begin
                frm_d      = '0;
                frm_done_d = 1'b1;
            end else begin
                frm_d = frm_q + FrmWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            frm_q      <= '0;
            frm_done_q <= 1'b0;
        end else begin
            frm_q      <= frm_d;
            frm_done_q <= frm_done_d;
        end
    end

    assign frm_cnt_o = frm_q;
    assign frm_done  = frm_done_q;

endmodule : frm_counter

`default_nettype wire

// File: rtl/cycle_counter_pgm.sv
// ============================================================================
// Module      : cycle_counter_pgm
// Description : Programmable up/down cycle counter with wrap/saturate and a
//               second-level frame counter for the serial-transfer datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cycle_counter_pgm
    import cnt_pkg::*;
#(
    parameter int Width    = 5,
    parameter int TcReset  = 16,
    parameter int Frames   = 4,
    parameter int FrmWidth = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          opc_i,
    input  logic [Width-1:0]    tc_i,
    input  logic                down_i,
    input  logic                wrap_en_i,
    output logic [Width-1:0]    cnt_o,
    output logic                flag_o,
    output logic                done_o,
    output logic [FrmWidth-1:0] frm_cnt_o,
    output logic                frm_done_o
);

    localparam logic [Width-1:0] TC_RST = Width'(TcReset);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;
    logic [Width-1:0] tc_q;
    logic [Width-1:0] tc_d;
    logic             done_q;
    logic             done_d;

    logic [Width-1:0] term_w;
    logic [Width-1:0] start_w;
    logic [Width-1:0] step_w;
    logic             at_term_w;
    logic             frm_inc_w;
    logic             frm_clr_w;

    always_comb begin
        term_w    = down_i ? '0 : tc_q;
        start_w   = Width'(start_value(down_i, 32'(tc_q)));
        at_term_w = (cnt_q == term_w);
        step_w    = down_i ? (cnt_q - Width'(1)) : (cnt_q + Width'(1));
    end

    always_comb begin
        cnt_d     = cnt_q;
        tc_d      = tc_q;
        done_d    = 1'b0;
        frm_inc_w = 1'b0;
        frm_clr_w = 1'b0;
        case (opc_e'(opc_i))
            OPC_COUNT: begin
                if (!at_term_w) begin
                    cnt_d  = step_w;
                    done_d = (step_w == term_w);
                end else if (wrap_en_i) begin
                    cnt_d     = start_w;
                    frm_inc_w = 1'b1;
                end
            end
            OPC_CLEAR: begin
                cnt_d     = start_w;
                frm_clr_w = 1'b1;
            end
            OPC_LOAD: begin
                // Start value comes from the incoming tc, not the stale tc_q.
                tc_d      = tc_i;
                cnt_d     = down_i ? tc_i : '0;
                frm_clr_w = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q  <= '0;
            tc_q   <= TC_RST;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tc_q   <= tc_d;
            done_q <= done_d;
        end
    end

    frm_counter #(
        .Frames   (Frames),
        .FrmWidth (FrmWidth)
    ) u_frm_counter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc       (frm_inc_w),
        .clr       (frm_clr_w),
        .frm_cnt_o (frm_cnt_o),
        .frm_done  (frm_done_o)
    );

    assign cnt_o  = cnt_q;
    assign flag_o = at_term_w;
    assign done_o = done_q;

endmodule : cycle_counter_pgm

`default_nettype wire

// File: tb/tb_cycle_counter_pgm.sv
// ============================================================================
// Module      : tb_cycle_counter_pgm
// Description : Directed self-checking bench for cycle_counter_pgm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cycle_counter_pgm;
    import cnt_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [1:0] opc_i;
    logic [4:0] tc_i;
    logic       down_i;
    logic       wrap_en_i;
    logic [4:0] cnt_o;
    logic       flag_o;
    logic       done_o;
    logic [1:0] frm_cnt_o;
    logic       frm_done_o;

    int n_cmp = 0;
    int n_err = 0;

    cycle_counter_pgm #(
        .Width    (5),
        .TcReset  (16),
        .Frames   (4),
        .FrmWidth (2)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .opc_i      (opc_i),
        .tc_i       (tc_i),
        .down_i     (down_i),
        .wrap_en_i  (wrap_en_i),
        .cnt_o      (cnt_o),
        .flag_o     (flag_o),
        .done_o     (done_o),
        .frm_cnt_o  (frm_cnt_o),
        .frm_done_o (frm_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one opcode for one rising edge; return at the following falling edge.
    task automatic step(input logic [1:0] opc);
        opc_i = opc;
        @(posedge clk_i);
        @(negedge clk_i);
        opc_i = OPC_HOLD;
    endtask

    task automatic check_all(input string tag, input int cnt, input int flag,
                             input int done, input int frm, input int frm_done);
        check_eq({tag, ".cnt"},      32'(cnt_o),      32'(cnt));
        check_eq({tag, ".flag"},     32'(flag_o),     32'(flag));
        check_eq({tag, ".done"},     32'(done_o),     32'(done));
        check_eq({tag, ".frm"},      32'(frm_cnt_o),  32'(frm));
        check_eq({tag, ".frm_done"}, 32'(frm_done_o), 32'(frm_done));
    endtask

    initial begin
        rst_i     = 1'b0;
        opc_i     = OPC_HOLD;
        tc_i      = 5'd0;
        down_i    = 1'b0;
        wrap_en_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_all("reset", 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Reset terminal count of 16, saturating
        for (int n = 1; n <= 16; n++) begin
            step(OPC_COUNT);
            check_all($sformatf("def%0d", n), n, (n == 16), (n == 16), 0, 0);
        end
        step(OPC_COUNT);
        check_all("def_sat", 16, 1, 0, 0, 0);

        // Load 5, wrapping: 6 counts per word, 24 per frame
        tc_i = 5'd5; wrap_en_i = 1'b1;
        step(OPC_LOAD);
        check_all("load5", 0, 0, 0, 0, 0);
        for (int n = 1; n <= 24; n++) begin
            step(OPC_COUNT);
            check_all($sformatf("wrap%0d", n), n % 6, (n % 6 == 5), (n % 6 == 5),
                      (n / 6) % 4, (n == 24));
        end

        // Down mode from 7
        tc_i = 5'd7; down_i = 1'b1;
        step(OPC_LOAD);
        check_all("dload", 7, 0, 0, 0, 0);
        for (int n = 1; n <= 7; n++) begin
            step(OPC_COUNT);
            check_all($sformatf("down%0d", n), 7 - n, (n == 7), (n == 7), 0, 0);
        end
        step(OPC_COUNT);
        check_all("down_wrap", 7, 0, 0, 1, 0);

        // Clear back to up mode, then mid-count hold and clear
        down_i = 1'b0;
        step(OPC_CLEAR);
        check_all("clr_up", 0, 0, 0, 0, 0);
        repeat (8) step(OPC_COUNT);
        check_all("word1", 0, 0, 0, 1, 0);
        repeat (3) step(OPC_COUNT);
        check_all("to3", 3, 0, 0, 1, 0);
        for (int n = 1; n <= 5; n++) begin
            step(OPC_HOLD);
            check_all($sformatf("hold%0d", n), 3, 0, 0, 1, 0);
        end
        step(OPC_CLEAR);
        check_all("clr_mid", 0, 0, 0, 0, 0);

        // Degenerate terminal of 0
        tc_i = 5'd0;
        step(OPC_LOAD);
        check_all("tc0", 0, 1, 0, 0, 0);
        for (int n = 1; n <= 8; n++) begin
            step(OPC_COUNT);
            check_all($sformatf("tc0_%0d", n), 0, 1, 0, n % 4, (n == 4 || n == 8));
        end

        // Asynchronous reset mid-frame at cnt 9, frame 2
        tc_i = 5'd16;
        step(OPC_LOAD);
        repeat (2 * 17 + 9) step(OPC_COUNT);
        check_all("prerst", 9, 0, 0, 2, 0);
        #2 rst_i = 1'b0;
        #1 check_all("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        wrap_en_i = 1'b0;
        @(negedge clk_i);
        check_all("post_rst", 0, 0, 0, 0, 0);
        repeat (15) step(OPC_COUNT);
        check_all("rst_tc15", 15, 0, 0, 0, 0);
        step(OPC_COUNT);
        check_all("rst_tc16", 16, 1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cycle_counter_pgm

`default_nettype wire
